// File: rtl/nfc_pkg.sv
// Shared constants and types for the NAND flash device-side interface.
// Opcodes, FSM encoding and status bytes used across the nfc slice.
package nfc_pkg;

    localparam int DAT_WID = 16;

    localparam logic [7:0] CMD_READ   = 8'h00;
    localparam logic [7:0] CMD_RD_GO  = 8'h30;
    localparam logic [7:0] CMD_PROG   = 8'h80;
    localparam logic [7:0] CMD_PG_GO  = 8'h10;
    localparam logic [7:0] CMD_ID     = 8'h90;
    localparam logic [7:0] CMD_STAT   = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] STAT_RDY = 8'hC0;
    localparam logic [7:0] STAT_BSY = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RD_CFM,
        S_BUSY,
        S_DOUT,
        S_DIN,
        S_STAT,
        S_ID
    } nf_st_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_PG,
        OP_ID
    } nf_op_t;

endpackage

// File: rtl/nf_busy_tmr.sv
// Busy-period down counter for tR/tPROG/reset.
// run is high while counting; done flags the edge where it reaches 0.
module nf_busy_tmr
    import nfc_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] count,
    output logic          done,
    output logic          run
);

    logic [CW-1:0] cnt;

    // load has priority so a reset command restarts a running period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= count;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign run  = (cnt != '0);
    assign done = (cnt == CW'(1));

endmodule

// File: rtl/nf_dev_if.sv
// Device side of a NAND flash bus: decodes CLE/ALE/WE#/RE# cycles,
// drives a page buffer and models tR/tPROG/reset busy periods.
module nf_dev_if #(
    parameter int          DAT_WID  = nfc_pkg::DAT_WID,
    parameter int          COL_CYC  = 2,
    parameter int          ROW_CYC  = 3,
    parameter int          PG_AW    = 12,
    parameter int          BUSY_CYC = 64,
    parameter int          RST_CYC  = 8,
    parameter logic [31:0] ID_WORD  = 32'hEC_D3_51_95
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               nf_cle,
    input  logic               nf_ale,
    input  logic               nf_web,
    input  logic               nf_reb,
    input  logic [DAT_WID-1:0] nf_din,
    output logic [DAT_WID-1:0] nf_dout,
    output logic               nf_doe,
    output logic               nf_rb,
    output logic [PG_AW-1:0]   buf_addr,
    output logic               buf_we,
    output logic [DAT_WID-1:0] buf_wdata,
    input  logic [DAT_WID-1:0] buf_rdata,
    output logic [31:0]        row_addr,
    output logic               op_rd,
    output logic               op_pg
);

    import nfc_pkg::*;

    localparam logic [2:0]  NCOL   = 3'(COL_CYC);
    localparam logic [2:0]  NTOT   = 3'(COL_CYC + ROW_CYC);
    localparam logic [15:0] BUSY_V = 16'(BUSY_CYC);
    localparam logic [15:0] RST_V  = 16'(RST_CYC);

    logic               web_q, reb_q, cle_q, ale_q;
    logic [DAT_WID-1:0] din_q;
    nf_st_t             state, state_n, after, after_n, dec_st;
    nf_op_t             op, op_n, dec_op;
    logic               ret, ret_n;
    logic [2:0]         acnt, aoff;
    logic [1:0]         idx;
    logic [PG_AW-1:0]   col;
    logic [31:0]        a_sh;
    logic [15:0]        ld_val;
    logic               ld, clr_adr, go_rd, go_pg;
    logic               tmr_done, tmr_run;
    logic               latch, rd_ev, is_cmd, is_adr, is_dat;
    logic               adr_ev, adr_last, wr_ev;
    logic [7:0]         cmd;

    assign latch  = !web_q && nf_web;
    assign rd_ev  = reb_q && !nf_reb;
    assign is_cmd = latch && cle_q && !ale_q;
    assign is_adr = latch && ale_q && !cle_q;
    assign is_dat = latch && !cle_q && !ale_q;
    assign cmd    = din_q[7:0];

    assign adr_ev   = is_adr && state == S_ADDR
                   && op != OP_ID && acnt < NTOT;
    assign adr_last = (op == OP_ID) ? (acnt == 3'd0)
                                    : (acnt == NTOT - 3'd1);
    assign wr_ev    = is_dat && state == S_DIN;
    assign aoff     = (acnt < NCOL) ? acnt : acnt - NCOL;
    assign a_sh     = {24'h0, din_q[7:0]} << {aoff, 3'b000};

    assign nf_rb    = !tmr_run;
    assign buf_addr = col;
    assign nf_doe   = !nf_reb && (state == S_DOUT
                   || state == S_STAT || state == S_ID);

    nf_busy_tmr #(.CW(16)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld),
        .count (ld_val),
        .done  (tmr_done),
        .run   (tmr_run)
    );

    // single register stage on all bus inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            web_q <= 1'b1;
            reb_q <= 1'b1;
            cle_q <= 1'b0;
            ale_q <= 1'b0;
            din_q <= '0;
        end else begin
            web_q <= nf_web;
            reb_q <= nf_reb;
            cle_q <= nf_cle;
            ale_q <= nf_ale;
            din_q <= nf_din;
        end
    end

    // opcode to target state for a plain command latch
    always_comb begin
        dec_st = S_IDLE;
        dec_op = op;
        unique case (cmd)
            CMD_READ:  begin dec_st = S_ADDR; dec_op = OP_RD; end
            CMD_PROG:  begin dec_st = S_ADDR; dec_op = OP_PG; end
            CMD_ID:    begin dec_st = S_ADDR; dec_op = OP_ID; end
            CMD_STAT:  dec_st = S_STAT;
            CMD_RESET: dec_st = S_BUSY;
            default:   dec_st = S_IDLE;
        endcase
    end

    // FSM state, post-busy target and status-return tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            after <= S_IDLE;
            op    <= OP_RD;
            ret   <= 1'b0;
        end else begin
            state <= state_n;
            after <= after_n;
            op    <= op_n;
            ret   <= ret_n;
        end
    end

    // next state; ret marks a status poll taken while busy
    always_comb begin
        state_n = state;
        after_n = after;
        op_n    = op;
        ret_n   = ret;
        ld      = 1'b0;
        ld_val  = BUSY_V;
        clr_adr = 1'b0;
        go_rd   = 1'b0;
        go_pg   = 1'b0;
        if (state == S_BUSY) begin
            if (is_cmd && cmd == CMD_RESET) begin
                ld      = 1'b1;
                ld_val  = RST_V;
                after_n = S_IDLE;
            end else if (is_cmd && cmd == CMD_STAT) begin
                state_n = S_STAT;
                ret_n   = 1'b1;
            end else if (tmr_done) begin
                state_n = after;
            end
        end else if (is_cmd && ret && tmr_run && !tmr_done
                     && cmd != CMD_RESET) begin
            if (cmd != CMD_STAT) begin
                state_n = S_BUSY;
                ret_n   = 1'b0;
            end
        end else if (is_cmd && state == S_RD_CFM
                     && cmd == CMD_RD_GO) begin
            state_n = S_BUSY;
            after_n = S_DOUT;
            ld      = 1'b1;
            go_rd   = 1'b1;
        end else if (is_cmd && state == S_DIN
                     && cmd == CMD_PG_GO) begin
            state_n = S_BUSY;
            after_n = S_IDLE;
            ld      = 1'b1;
            go_pg   = 1'b1;
        end else if (is_cmd) begin
            state_n = dec_st;
            op_n    = dec_op;
            ret_n   = 1'b0;
            clr_adr = (dec_st == S_ADDR);
            if (dec_st == S_BUSY) begin
                ld      = 1'b1;
                ld_val  = RST_V;
                after_n = S_IDLE;
            end
        end else if (state == S_ADDR && is_adr && adr_last) begin
            if (op == OP_RD) state_n = S_RD_CFM;
            else if (op == OP_PG) state_n = S_DIN;
            else state_n = S_ID;
        end
    end

    // address capture, column counter, buffer strobes and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row_addr  <= '0;
            acnt      <= '0;
            idx       <= '0;
            nf_dout   <= '0;
            buf_we    <= 1'b0;
            buf_wdata <= '0;
            op_rd     <= 1'b0;
            op_pg     <= 1'b0;
        end else begin
            op_rd  <= go_rd;
            op_pg  <= go_pg;
            buf_we <= wr_ev;
            if (wr_ev) buf_wdata <= din_q;
            if (clr_adr) begin
                col      <= '0;
                row_addr <= '0;
                acnt     <= '0;
                idx      <= '0;
            end else if (adr_ev) begin
                acnt <= acnt + 3'd1;
                if (acnt < NCOL) col <= col | PG_AW'(a_sh);
                else row_addr <= row_addr | a_sh;
            end else if (buf_we) begin
                col <= col + PG_AW'(1);
            end else if (rd_ev && state == S_DOUT) begin
                col <= col + PG_AW'(1);
            end
            if (rd_ev) begin
                unique case (state)
                    S_DOUT: nf_dout <= buf_rdata;
                    S_STAT: nf_dout <= DAT_WID'(tmr_run ? STAT_BSY
                                                        : STAT_RDY);
                    S_ID: begin
                        nf_dout <= DAT_WID'(8'(ID_WORD >> {~idx, 3'b000}));
                        idx     <= idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nf_dev_if.sv
// Scoreboard bench for nf_dev_if: directed NAND cycles push expected
// outputs; a negedge monitor pops and compares what the DUT presents.
module tb_nf_dev_if;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_OR = 2;
    localparam int K_OP = 3;

    typedef struct {
        int          k;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nf_cle = 1'b0, nf_ale = 1'b0;
    logic        nf_web = 1'b1, nf_reb = 1'b1;
    logic [15:0] nf_din = '0;
    logic [15:0] nf_dout, buf_wdata, buf_rdata;
    logic        nf_doe, nf_rb, buf_we, op_rd, op_pg;
    logic [11:0] buf_addr;
    logic [31:0] row_addr;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nf_dev_if #(
        .DAT_WID(16), .COL_CYC(2), .ROW_CYC(3), .PG_AW(12),
        .BUSY_CYC(64), .RST_CYC(8), .ID_WORD(32'hECD35195)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .nf_cle(nf_cle), .nf_ale(nf_ale),
        .nf_web(nf_web), .nf_reb(nf_reb),
        .nf_din(nf_din), .nf_dout(nf_dout), .nf_doe(nf_doe),
        .nf_rb(nf_rb), .buf_addr(buf_addr), .buf_we(buf_we),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .row_addr(row_addr), .op_rd(op_rd), .op_pg(op_pg)
    );

    // page buffer model: word at column c reads as {4'hB, c}
    always @(posedge clk) buf_rdata <= {4'hB, buf_addr};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.k = k;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic mon(input int k, input logic [31:0] v);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected kind %0d: got %h, expected none",
                     k, v);
        end else begin
            e = sb.pop_front();
            chk($sformatf("kind%0d", e.k), {k[3:0], v[27:0]},
                {e.k[3:0], e.v[27:0]});
        end
    endtask

    // monitor: read data one cycle after RE# falls, writes and op pulses
    initial begin
        logic rp, arm;
        rp  = 1'b1;
        arm = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rp  = 1'b1;
                arm = 1'b0;
            end else begin
                if (arm) mon(K_RD, {16'h0, nf_dout});
                arm = rp && !nf_reb && nf_doe;
                rp  = nf_reb;
                if (buf_we) mon(K_WR, {4'h0, buf_addr, buf_wdata});
                if (op_rd) mon(K_OR, row_addr);
                if (op_pg) mon(K_OP, row_addr);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic c, input logic a,
                         input logic [15:0] d);
        nf_cle = c;
        nf_ale = a;
        nf_din = d;
        nf_web = 1'b0;
        tick;
        tick;
        nf_web = 1'b1;
        tick;
        nf_cle = 1'b0;
        nf_ale = 1'b0;
        tick;
    endtask

    task automatic addr5(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2);
        latch(0, 1, {8'h0, a0});
        latch(0, 1, {8'h0, a1});
        latch(0, 1, {8'h0, a2});
        latch(0, 1, 16'h0);
        latch(0, 1, 16'h0);
    endtask

    task automatic rd;
        nf_reb = 1'b0;
        tick;
        tick;
        nf_reb = 1'b1;
        tick;
        tick;
    endtask

    // issue a command and count the cycles nf_rb stays low
    task automatic cmd_busy(input logic [7:0] c, input int exp,
                            input string nm);
        int n;
        n = 0;
        nf_cle = 1'b1;
        nf_din = {8'h0, c};
        nf_web = 1'b0;
        tick;
        tick;
        nf_web = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick;
            nf_cle = 1'b0;
            if (nf_rb) break;
            n++;
        end
        chk(nm, n, exp);
    endtask

    task automatic wait_rdy;
        for (int i = 0; i < 500; i++) begin
            if (nf_rb) break;
            tick;
        end
        chk("rdy_wait", {31'h0, nf_rb}, 32'h1);
    endtask

    task automatic rst_chk;
        chk("rst_rb", {31'h0, nf_rb}, 32'h1);
        chk("rst_dout", {16'h0, nf_dout}, 32'h0);
        chk("rst_doe", {31'h0, nf_doe}, 32'h0);
        chk("rst_we", {31'h0, buf_we}, 32'h0);
        chk("rst_addr", {20'h0, buf_addr}, 32'h0);
        chk("rst_wdata", {16'h0, buf_wdata}, 32'h0);
        chk("rst_row", row_addr, 32'h0);
        chk("rst_ops", {30'h0, op_rd, op_pg}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        rst_chk;
        rst_n = 1'b1;
        tick;
        tick;

        // read ID: five bytes, index wraps
        latch(1, 0, 16'h0090);
        latch(0, 1, 16'h0000);
        push(K_RD, 32'h00EC);
        push(K_RD, 32'h00D3);
        push(K_RD, 32'h0051);
        push(K_RD, 32'h0095);
        push(K_RD, 32'h00EC);
        repeat (5) rd;

        // program two words at column 4, row 1
        latch(1, 0, 16'h0080);
        addr5(8'h04, 8'h00, 8'h01);
        push(K_WR, 32'h0004_AAAA);
        latch(0, 0, 16'hAAAA);
        push(K_WR, 32'h0005_5555);
        latch(0, 0, 16'h5555);
        push(K_OP, 32'h1);
        cmd_busy(8'h10, 64, "pg_busy_len");

        // page read from column 0xFFE with wrap
        latch(1, 0, 16'h0000);
        addr5(8'hFE, 8'h0F, 8'h02);
        push(K_OR, 32'h2);
        latch(1, 0, 16'h0030);
        wait_rdy;
        push(K_RD, 32'hBFFE);
        push(K_RD, 32'hBFFF);
        push(K_RD, 32'hB000);
        repeat (3) rd;

        // status during and after a program busy
        latch(1, 0, 16'h0080);
        addr5(8'h00, 8'h00, 8'h00);
        push(K_OP, 32'h0);
        latch(1, 0, 16'h0010);
        latch(1, 0, 16'h0070);
        chk("stat_rb", {31'h0, nf_rb}, 32'h0);
        push(K_RD, 32'h0080);
        rd;
        wait_rdy;
        push(K_RD, 32'h00C0);
        rd;

        // reset command restarts busy mid-program
        latch(1, 0, 16'h0080);
        addr5(8'h00, 8'h00, 8'h00);
        push(K_OP, 32'h0);
        latch(1, 0, 16'h0010);
        repeat (5) tick;
        cmd_busy(8'hFF, 8, "rst_busy_len");
        nf_reb = 1'b0;
        tick;
        chk("idle_doe", {31'h0, nf_doe}, 32'h0);
        nf_reb = 1'b1;
        tick;

        // async reset while streaming out
        latch(1, 0, 16'h0000);
        addr5(8'h10, 8'h00, 8'h03);
        push(K_OR, 32'h3);
        latch(1, 0, 16'h0030);
        wait_rdy;
        push(K_RD, 32'hB010);
        rd;
        push(K_RD, 32'hB011);
        nf_reb = 1'b0;
        tick;
        tick;
        chk("dout_doe", {31'h0, nf_doe}, 32'h1);
        rst_n = 1'b0;
        #1;
        rst_chk;
        tick;
        nf_reb = 1'b1;
        rst_n = 1'b1;
        tick;
        tick;

        chk("sb_left", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
